operand_fetch: RTL and testbench

//   Operand-fetch stage directly upstream of the 16-bit shifter in the lab datapath.

---
 rtl/operand_fetch_pkg.sv | 20 ++
 rtl/operand_fetch_regfile.sv | 29 ++
 rtl/operand_fetch.sv | 103 ++++++++++
 tb/tb_operand_fetch.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared widths, FSM state encoding and shift codes for the operand-fetch stage.
package operand_fetch_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int REG_AW = $clog2(NREG);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_A = 2'd1,
    ST_LOAD_B = 2'd2,
    ST_ISSUE  = 2'd3
  } state_e;

  localparam logic [1:0] SHIFT_PASS = 2'b00;
  localparam logic [1:0] SHIFT_LSL  = 2'b01;
  localparam logic [1:0] SHIFT_LSR  = 2'b10;
  localparam logic [1:0] SHIFT_ASR  = 2'b11;

endpackage

// File: rtl/operand_fetch_regfile.sv
// Architectural register file: one synchronous write port, one combinational
// read port, cleared by the asynchronous reset.
module op_regfile
  import operand_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en_i,
  input  logic [REG_AW-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] regs_q [NREG];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = regs_q[rd_addr_i];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads Rn then Rm into the A/B latches and hands them,
// with the shift code, to the shifter over a valid/ready handshake.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [REG_AW-1:0] rn,
  input  logic [REG_AW-1:0] rm,
  input  logic [1:0]        shift_in,
  output logic              busy,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [1:0]        shift_out
);

  state_e            state_q, state_d;
  logic [REG_AW-1:0] rn_q, rn_d, rm_q, rm_d;
  logic [1:0]        shift_q, shift_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [REG_AW-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] fetch_data;

  assign rd_addr = (state_q == ST_LOAD_B) ? rm_q : rn_q;

  op_regfile u_regfile (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (wb_en),
    .wr_addr_i (wb_reg),
    .wr_data_i (wb_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // A write landing on the register being fetched this cycle must win over the stale copy.
  assign fetch_data = (wb_en && (wb_reg == rd_addr)) ? wb_data : rd_data;

  always_comb begin
    state_d = state_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    shift_d = shift_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rn_d    = rn;
          rm_d    = rm;
          shift_d = shift_in;
          state_d = ST_LOAD_A;
        end
      end
      ST_LOAD_A: begin
        a_d     = fetch_data;
        state_d = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        b_d     = fetch_data;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rn_q    <= '0;
      rm_q    <= '0;
      shift_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      shift_q <= shift_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_ISSUE);
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign shift_out = shift_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized
// operations checked against a register-array reference model.
module tb_operand_fetch;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  rn, rm;
  logic [1:0]  shift_in;
  logic        busy;
  logic        wb_en;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] a_out, b_out;
  logic [1:0]  shift_out;

  logic [15:0] modelReg [8];
  int          assertCount = 0;
  int          failCount   = 0;

  operand_fetch dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .rn        (rn),
    .rm        (rm),
    .shift_in  (shift_in),
    .busy      (busy),
    .wb_en     (wb_en),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .shift_out (shift_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock edge; the model commits whatever write the inputs present at that edge.
  task automatic cycle();
    @(posedge clk);
    if (reset_n && wb_en) modelReg[wb_reg] = wb_data;
    #1;
  endtask

  task automatic clearModel();
    for (int i = 0; i < 8; i++) modelReg[i] = 16'h0000;
  endtask

  task automatic writeReg(input logic [2:0] r, input logic [15:0] d);
    wb_en = 1'b1; wb_reg = r; wb_data = d;
    cycle();
    wb_en = 1'b0;
  endtask

  task automatic driveWb(input bit randWb, input int stage, input int forceStage,
                         input logic [2:0] forceReg, input logic [15:0] forceData,
                         input logic [2:0] hintReg);
    wb_en   = randWb ? 1'($urandom_range(0, 1)) : 1'b0;
    wb_reg  = ($urandom_range(0, 2) == 0) ? hintReg : 3'($urandom);
    wb_data = 16'($urandom);
    if (stage == forceStage) begin
      wb_en = 1'b1; wb_reg = forceReg; wb_data = forceData;
    end
  endtask

  // A fetched operand equals the register contents as they stand right after
  // the edge that loads it (a same-edge write is forwarded).
  task automatic applyStimulus(input logic [2:0] rnV, input logic [2:0] rmV, input logic [1:0] shV,
                               input int hold, input bit randWb, input int forceStage,
                               input logic [2:0] forceReg, input logic [15:0] forceData);
    logic [15:0] expA, expB;
    checkOutput("idleBusy", 32'(busy), 32'd0);
    checkOutput("idleValid", 32'(out_valid), 32'd0);
    start = 1'b1; rn = rnV; rm = rmV; shift_in = shV; out_ready = 1'b0;
    driveWb(randWb, 0, forceStage, forceReg, forceData, rnV);
    cycle();
    start = 1'b0; rn = 3'($urandom); rm = 3'($urandom); shift_in = 2'($urandom);
    checkOutput("loadABusy", 32'(busy), 32'd1);
    checkOutput("loadAValid", 32'(out_valid), 32'd0);
    start = 1'($urandom_range(0, 1));
    driveWb(randWb, 1, forceStage, forceReg, forceData, rnV);
    cycle();
    expA = modelReg[rnV];
    checkOutput("loadBValid", 32'(out_valid), 32'd0);
    start = 1'($urandom_range(0, 1));
    driveWb(randWb, 2, forceStage, forceReg, forceData, rmV);
    cycle();
    expB = modelReg[rmV];
    for (int i = 0; i <= hold; i++) begin
      checkOutput("issueValid", 32'(out_valid), 32'd1);
      checkOutput("issueBusy", 32'(busy), 32'd1);
      checkOutput("issueA", 32'(a_out), 32'(expA));
      checkOutput("issueB", 32'(b_out), 32'(expB));
      checkOutput("issueShift", 32'(shift_out), 32'(shV));
      out_ready = (i == hold);
      start = 1'b1;
      driveWb(randWb, 3, forceStage, forceReg, forceData, rnV);
      cycle();
    end
    start = 1'b0; wb_en = 1'b0; out_ready = 1'b0;
    checkOutput("doneValid", 32'(out_valid), 32'd0);
    checkOutput("doneBusy", 32'(busy), 32'd0);
    checkOutput("holdA", 32'(a_out), 32'(expA));
    checkOutput("holdB", 32'(b_out), 32'(expB));
    checkOutput("holdShift", 32'(shift_out), 32'(shV));
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; rn = '0; rm = '0; shift_in = '0;
    wb_en = 1'b0; wb_reg = '0; wb_data = '0; out_ready = 1'b0;
    clearModel();
    #2;
    checkOutput("rstValid", 32'(out_valid), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstA", 32'(a_out), 32'd0);
    checkOutput("rstB", 32'(b_out), 32'd0);
    checkOutput("rstShift", 32'(shift_out), 32'd0);
    #10;
    reset_n = 1'b1;
    cycle();

    writeReg(3'd3, 16'h1234);
    writeReg(3'd5, 16'h00F0);
    applyStimulus(3'd3, 3'd5, 2'b01, 0, 1'b0, -1, 3'd0, 16'h0);
    checkOutput("t1A", 32'(a_out), 32'h1234);
    checkOutput("t1B", 32'(b_out), 32'h00F0);
    checkOutput("t1Shift", 32'(shift_out), 32'h1);

    applyStimulus(3'd3, 3'd5, 2'b10, 5, 1'b0, -1, 3'd0, 16'h0);

    applyStimulus(3'd1, 3'd5, 2'b00, 0, 1'b0, 2, 3'd5, 16'hBEEF);
    checkOutput("t3Bypass", 32'(b_out), 32'hBEEF);
    applyStimulus(3'd5, 3'd0, 2'b00, 0, 1'b0, -1, 3'd0, 16'h0);
    checkOutput("t3Reread", 32'(a_out), 32'hBEEF);

    writeReg(3'd7, 16'h8001);
    applyStimulus(3'd7, 3'd7, 2'b11, 1, 1'b0, -1, 3'd0, 16'h0);
    checkOutput("t4A", 32'(a_out), 32'h8001);
    checkOutput("t4B", 32'(b_out), 32'h8001);

    applyStimulus(3'd3, 3'd2, 2'b00, 2, 1'b0, 3, 3'd3, 16'h5555);
    checkOutput("t6OldA", 32'(a_out), 32'h1234);
    applyStimulus(3'd3, 3'd2, 2'b00, 0, 1'b0, -1, 3'd0, 16'h0);
    checkOutput("t6NewA", 32'(a_out), 32'h5555);

    start = 1'b1; rn = 3'd3; rm = 3'd5; shift_in = 2'b01;
    cycle();
    start = 1'b0;
    cycle();
    #2;
    reset_n = 1'b0;
    #1;
    clearModel();
    checkOutput("abortValid", 32'(out_valid), 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortA", 32'(a_out), 32'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    cycle();
    applyStimulus(3'd3, 3'd5, 2'b00, 0, 1'b0, -1, 3'd0, 16'h0);
    checkOutput("t5A", 32'(a_out), 32'h0000);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) writeReg(3'($urandom), 16'($urandom));
      applyStimulus(3'($urandom), 3'($urandom), 2'($urandom), int'($urandom_range(0, 3)),
                    1'b1, int'($urandom_range(0, 4)), 3'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
